// File: rtl/hazard3_onehot_priority.sv
// Priority selector: reduces a request bitmap to a one-hot (or zero) vector.
// HIGHEST_WINS=0 keeps the lowest set bit, HIGHEST_WINS=1 keeps the highest.
module hazard3_onehot_priority #(
    parameter int W            = 4,
    parameter bit HIGHEST_WINS = 1'b0
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] gnt
);

    logic seen_any;

    // seen_any tracks whether a higher-priority bit has already been taken.
    always_comb begin
        gnt      = '0;
        seen_any = 1'b0;
        if (!HIGHEST_WINS) begin
            for (int i = 0; i < W; i++) begin
                gnt[i]   = req[i] & ~seen_any;
                seen_any = seen_any | req[i];
            end
        end else begin
            for (int i = W - 1; i >= 0; i--) begin
                gnt[i]   = req[i] & ~seen_any;
                seen_any = seen_any | req[i];
            end
        end
    end

endmodule

// File: rtl/hazard3_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and zero-bubble handover.
// Optional grant lock across done is enabled by defining HAZARD3_RR_ARBITER_LOCK_EN.
module hazard3_rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int W_IDX = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
`ifdef HAZARD3_RR_ARBITER_LOCK_EN
    input  logic             lock,
`endif
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [W_IDX-1:0] gnt_idx
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [N_REQ-1:0]   gnt_reg, gnt_next;
    logic [W_IDX-1:0]   gnt_idx_reg, gnt_idx_next;
    logic               gnt_valid_reg, gnt_valid_next;
    logic [W_IDX-1:0]   last_reg, last_next;

    logic [N_REQ-1:0]   masked_req;
    logic [N_REQ-1:0]   masked_oh;
    logic [N_REQ-1:0]   raw_oh;
    logic [N_REQ-1:0]   win_oh;
    logic [W_IDX-1:0]   win_idx;
    logic               hold_grant;

    // Only requesters strictly above the last grant take part in the first pass.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign masked_req[gi] = req[gi] & (W_IDX'(gi) > last_reg);
        end
    endgenerate

    hazard3_onehot_priority #(
        .W            (N_REQ),
        .HIGHEST_WINS (1'b0)
    ) u_pri_masked (
        .req (masked_req),
        .gnt (masked_oh)
    );

    hazard3_onehot_priority #(
        .W            (N_REQ),
        .HIGHEST_WINS (1'b0)
    ) u_pri_raw (
        .req (req),
        .gnt (raw_oh)
    );

    assign win_oh = (|masked_req) ? masked_oh : raw_oh;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx = win_idx | W_IDX'(i);
            end
        end
    end

`ifdef HAZARD3_RR_ARBITER_LOCK_EN
    assign hold_grant = lock;
`else
    assign hold_grant = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        gnt_idx_next   = gnt_idx_reg;
        last_next      = last_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next   = BUSY;
                    gnt_next     = win_oh;
                    gnt_idx_next = win_idx;
                    last_next    = win_idx;
                end
            end
            BUSY: begin
                if (done && !hold_grant) begin
                    if (|req) begin
                        gnt_next     = win_oh;
                        gnt_idx_next = win_idx;
                        last_next    = win_idx;
                    end else begin
                        state_next   = IDLE;
                        gnt_next     = '0;
                        gnt_idx_next = '0;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                gnt_next     = '0;
                gnt_idx_next = '0;
            end
        endcase
        gnt_valid_next = (state_next == BUSY);
    end

    // Pointer resets to the top index so requester 0 is favoured first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            gnt_idx_reg   <= '0;
            gnt_valid_reg <= 1'b0;
            last_reg      <= W_IDX'(N_REQ - 1);
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            gnt_idx_reg   <= gnt_idx_next;
            gnt_valid_reg <= gnt_valid_next;
            last_reg      <= last_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_valid = gnt_valid_reg;
    assign gnt_idx   = gnt_idx_reg;

endmodule

// File: tb/tb_hazard3_rr_arbiter.sv
// Self-checking bench for hazard3_rr_arbiter (N_REQ=4): vector table, directed
// corner sequences and randomized traffic against a cyclic-search reference model.
module tb_hazard3_rr_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         done;
    logic         lock;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_idx;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_busy;
    int m_last;

    always #5 clk = ~clk;

    hazard3_rr_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
`ifdef HAZARD3_RR_ARBITER_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    typedef struct {
        logic [N-1:0] req;
        logic         done;
        logic [N-1:0] gnt;
        logic [1:0]   idx;
        logic         valid;
    } vec_t;

    vec_t tbl[20];

    task automatic drive(input logic [N-1:0] r, input logic d, input logic rs);
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [N-1:0] eg,
                         input logic [1:0] ei, input logic ev);
        total++;
        if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev) begin
            bad++;
            $display("FAIL %s gnt=%b idx=%0d valid=%b expected gnt=%b idx=%0d valid=%b",
                     name, gnt, gnt_idx, gnt_valid, eg, ei, ev);
        end else begin
            $display("ok   %s req=%b done=%b gnt=%b idx=%0d valid=%b",
                     name, req, done, gnt, gnt_idx, gnt_valid);
        end
    endtask

    // Next index in cyclic order after l that is requesting; -1 if none.
    function automatic int pick(input logic [N-1:0] r, input int l);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (l + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic d, input logic rs);
        int w;
        w = pick(r, m_last);
        if (rs) begin
            m_busy = 1'b0;
            m_last = N - 1;
        end else if (!m_busy) begin
            if (w >= 0) begin
                m_busy = 1'b1;
                m_last = w;
            end
        end else if (d) begin
            if (w >= 0) m_last = w;
            else        m_busy = 1'b0;
        end
    endtask

    task automatic do_reset();
        drive('0, 1'b0, 1'b1);
        drive('0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] r;
        logic         d;
        logic         rs;
        logic [N-1:0] eg;

        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        lock = 1'b0;

        tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
        tbl[5]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1};
        tbl[6]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[10] = '{4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1};
        tbl[11] = '{4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1};
        tbl[12] = '{4'b1000, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[13] = '{4'b1000, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[14] = '{4'b1000, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[15] = '{4'b1000, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[16] = '{4'b1000, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[17] = '{4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1};
        tbl[18] = '{4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1};
        tbl[19] = '{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1};

        do_reset();
        check("reset", 4'b0000, 2'd0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].req, tbl[i].done, 1'b0);
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].valid);
        end

        // First grant after reset, one-cycle latency
        do_reset();
        drive(4'b1010, 1'b0, 1'b0);
        check("first_grant", 4'b0010, 2'd1, 1'b1);

        // Reset while busy on index 2, then fresh arbitration from index 0
        do_reset();
        drive(4'b0100, 1'b0, 1'b0);
        check("busy2", 4'b0100, 2'd2, 1'b1);
        drive(4'b0100, 1'b1, 1'b1);
        check("rst_busy", 4'b0000, 2'd0, 1'b0);
        drive(4'b0101, 1'b0, 1'b0);
        check("post_rst", 4'b0001, 2'd0, 1'b1);

`ifdef HAZARD3_RR_ARBITER_LOCK_EN
        do_reset();
        drive(4'b1000, 1'b0, 1'b0);
        check("lock_g3", 4'b1000, 2'd3, 1'b1);
        lock = 1'b1;
        drive(4'b1001, 1'b1, 1'b0);
        check("lock_hold", 4'b1000, 2'd3, 1'b1);
        lock = 1'b0;
        drive(4'b1001, 1'b1, 1'b0);
        check("lock_release", 4'b0001, 2'd0, 1'b1);
`endif

        // Randomized traffic against the reference model
        do_reset();
        m_busy = 1'b0;
        m_last = N - 1;
        for (int t = 0; t < 300; t++) begin
            r  = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = '0;
            d  = ($urandom_range(0, 2) != 0);
            rs = ($urandom_range(0, 39) == 0);
            drive(r, d, rs);
            model_step(r, d, rs);
            eg = m_busy ? N'(1 << m_last) : '0;
            check($sformatf("rnd%0d", t), eg, m_busy ? 2'(m_last) : 2'd0, m_busy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard3_rr_arbiter.md
HAZARD3_RR_ARBITER -- requirements
Module: hazard3_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters; legal range 2..16.
REQ-002 Localparam W_IDX = max(1, $clog2(N_REQ)), width of the grant index.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req  input  N_REQ  per-requester request bitmap; a requester holds its bit until its transfer's done.
REQ-006 done  input  1  one-cycle pulse: the current granted transfer completes this cycle.
REQ-007 lock  input  1  present only with HAZARD3_RR_ARBITER_LOCK_EN; keep the current grant across done.
REQ-008 gnt  output  N_REQ  registered grant; one-hot or zero.
REQ-009 gnt_valid  output  1  registered; equals |gnt.
REQ-010 gnt_idx  output  W_IDX  registered binary index of the set gnt bit; 0 when gnt_valid=0.

Function
REQ-011 State machine has two states: IDLE (gnt=0) and BUSY (gnt one-hot, held constant).
REQ-012 Round-robin pointer last[W_IDX-1:0] records the most recently granted index.
REQ-013 Arbitration: masked = req bits with index > last; winner = lowest set bit of masked if nonzero, else lowest set bit of req.
REQ-014 IDLE with req!=0: next cycle BUSY, gnt=onehot(winner), gnt_idx=winner, last=winner (1-cycle latency).
REQ-015 IDLE with req==0: stay IDLE; done ignored.
REQ-016 BUSY with done=0: gnt, gnt_idx, last unchanged, regardless of req changes.
REQ-017 BUSY with done=1 and req!=0: re-arbitrate the same cycle using current last; next cycle BUSY with the new winner (zero-bubble handover).
REQ-018 BUSY with done=1 and req==0: next cycle IDLE, gnt=0; last retained.
REQ-019 Current holder still requesting at done gets lowest priority (round-robin rule); it wins again only if it is the sole requester.
REQ-020 A granted requester dropping req before done is a protocol violation; the arbiter keeps gnt until done.
REQ-021 Bits of req at index >= N_REQ do not exist; there is no wrap-around beyond N_REQ-1 (masked empty -> fall back to unmasked).

Reset
REQ-022 rst=1 at a clock edge forces IDLE, gnt=0, gnt_valid=0, gnt_idx=0, last=N_REQ-1 (so requester 0 has highest priority after reset).
REQ-023 rst asserted mid-transfer drops the grant the following cycle; done and lock on that cycle are ignored.

Configuration
REQ-024 Macro HAZARD3_RR_ARBITER_LOCK_EN defined: lock port exists; BUSY with done=1 and lock=1 stays BUSY with the same gnt, last unchanged.
REQ-025 Macro undefined: no lock port; behaviour exactly as REQ-016..REQ-018.

Structure
REQ-026 No shared package; state encoding (IDLE=0, BUSY=1) is a local constant.
REQ-027 Lowest-set-bit selection uses two instances of hazard3_onehot_priority (HIGHEST_WINS=0), one for masked req, one for raw req; no other sub-module.
REQ-028 One-hot-to-index encoding is a local OR-reduction loop.

Verification
REQ-029 N_REQ=4, reset, req=4'b1010 -> 1 cycle later gnt=4'b0010, gnt_idx=1.
REQ-030 Holding req=4'b1111, pulse done each BUSY cycle -> grant order 0,1,2,3,0 with no idle cycle between grants.
REQ-031 Grant to 2, req=4'b0100 only, done -> gnt=4'b0100 again next cycle; then req=0, done -> gnt=0, gnt_valid=0.
REQ-032 Grant to 1, req changes to 4'b1000 with done=0 for 5 cycles -> gnt stays 4'b0010 throughout.
REQ-033 With LOCK_EN: grant to 3, done=1 and lock=1 with req=4'b1001 -> gnt stays 4'b1000; done with lock=0 -> gnt=4'b0001.
REQ-034 rst pulsed while BUSY on index 2 -> next cycle gnt=0; then req=4'b0101 -> gnt=4'b0001.
